// File: rtl/sram_bus_arbiter_if.sv
// sram_bus_arbiter_if: SRAM-like split address/data bus.
//   Requester side (master) drives req/wr/size/wstrb/addr/wdata and
//   receives addr_ok (address accepted), data_ok (response) and rdata.
//   The responder side (slave) sees the opposite directions.
interface sram_bus_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-like memory port between the
// instruction-fetch requester and the data requester.
//   clk, reset   : clock, synchronous active-high reset
//   inst (slave) : instruction-fetch requester bus
//   data (slave) : data requester bus
//   mem  (master): downstream memory bus
//   err_sticky   : set when a response arrives with nothing outstanding
// Data has priority unless inst has been passed over STARVE_LIMIT times in a
// row. The grant is locked until the address is accepted and exactly one
// transaction may be outstanding. Handshake outputs are combinational so the
// address can be accepted in the request cycle and the response forwarded in
// the cycle it arrives.
module sram_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  sram_bus_arbiter_if.slave    inst,
  sram_bus_arbiter_if.slave    data,
  sram_bus_arbiter_if.master   mem,
  output logic                 err_sticky
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] REQ_INST  = 3'd1;
  localparam logic [2:0] REQ_DATA  = 3'd2;
  localparam logic [2:0] WAIT_INST = 3'd3;
  localparam logic [2:0] WAIT_DATA = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             err_sticky_q, err_sticky_d;

  logic own_data_c;   // mem fields and addr_ok belong to the data requester
  logic mem_req_c;
  logic grant_c;      // address handshake this cycle
  logic inst_dok_c;
  logic data_dok_c;
  logic waiting_c;

  // State, starvation counter and error flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  // Next-state, arbitration and handshake decode
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    err_sticky_d = err_sticky_q;
    own_data_c   = 1'b0;
    mem_req_c    = 1'b0;
    grant_c      = 1'b0;
    inst_dok_c   = 1'b0;
    data_dok_c   = 1'b0;
    waiting_c    = 1'b0;

    case (state_q)
      IDLE: begin
        // Data wins unless inst is pending and has hit the starvation limit
        own_data_c = data.req && !(inst.req && (starve_cnt_q == CNT_MAX));
        mem_req_c  = inst.req || data.req;
        if (mem_req_c) begin
          if (mem.addr_ok) begin
            grant_c = 1'b1;
            state_d = own_data_c ? WAIT_DATA : WAIT_INST;
          end else begin
            state_d = own_data_c ? REQ_DATA : REQ_INST;
          end
        end
      end
      REQ_INST: begin
        mem_req_c = 1'b1;
        if (mem.addr_ok) begin
          grant_c = 1'b1;
          state_d = WAIT_INST;
        end
      end
      REQ_DATA: begin
        own_data_c = 1'b1;
        mem_req_c  = 1'b1;
        if (mem.addr_ok) begin
          grant_c = 1'b1;
          state_d = WAIT_DATA;
        end
      end
      WAIT_INST: begin
        waiting_c = 1'b1;
        if (mem.data_ok) begin
          inst_dok_c = 1'b1;
          state_d    = IDLE;
        end
      end
      WAIT_DATA: begin
        waiting_c  = 1'b1;
        own_data_c = 1'b1;
        if (mem.data_ok) begin
          data_dok_c = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Starvation counter moves only on an accepted address
    if (grant_c) begin
      if (own_data_c && inst.req) begin
        if (starve_cnt_q != CNT_MAX) begin
          starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
      end else begin
        starve_cnt_d = '0;
      end
    end

    // A response with nothing outstanding is dropped and flagged
    if (mem.data_ok && !waiting_c) begin
      err_sticky_d = 1'b1;
    end
  end

  // Handshake outputs, held inactive during reset
  always_comb begin
    mem.req      = mem_req_c && !reset;
    inst.addr_ok = grant_c && !own_data_c && !reset;
    data.addr_ok = grant_c && own_data_c && !reset;
    inst.data_ok = inst_dok_c && !reset;
    data.data_ok = data_dok_c && !reset;
    inst.rdata   = mem.rdata;
    data.rdata   = mem.rdata;
  end

  // Downstream field mux follows the current owner
  always_comb begin
    mem.wr    = own_data_c ? data.wr    : inst.wr;
    mem.size  = own_data_c ? data.size  : inst.size;
    mem.wstrb = own_data_c ? data.wstrb : inst.wstrb;
    mem.addr  = own_data_c ? data.addr  : inst.addr;
    mem.wdata = own_data_c ? data.wdata : inst.wdata;
  end

  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
module tb_sram_bus_arbiter;

  logic clk;
  logic reset;
  logic err_sticky;
  int   n_checks;
  int   n_errors;

  sram_bus_arbiter_if inst_bus ();
  sram_bus_arbiter_if data_bus ();
  sram_bus_arbiter_if mem_bus ();

  sram_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .inst       (inst_bus),
    .data       (data_bus),
    .mem        (mem_bus),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; checks run 1ns later
  task automatic fall();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic quiet_inputs();
    inst_bus.req = 1'b0; inst_bus.wr = 1'b0; inst_bus.size = 2'd2;
    inst_bus.wstrb = 4'h0; inst_bus.addr = '0; inst_bus.wdata = '0;
    data_bus.req = 1'b0; data_bus.wr = 1'b0; data_bus.size = 2'd2;
    data_bus.wstrb = 4'h0; data_bus.addr = '0; data_bus.wdata = '0;
    mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b0; mem_bus.rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clk = 1'b0;
    n_checks = 0;
    n_errors = 0;
    quiet_inputs();
    reset = 1'b1;

    // Reset: outputs held low even with a request and addr_ok present
    inst_bus.req = 1'b1; inst_bus.addr = 32'h1c000000; mem_bus.addr_ok = 1'b1;
    fall(); settle();
    chk_eq("rst_mem_req", mem_bus.req, 1'b0);
    chk_eq("rst_inst_addr_ok", inst_bus.addr_ok, 1'b0);
    chk_eq("rst_err", err_sticky, 1'b0);
    fall(); quiet_inputs(); reset = 1'b0;

    // Single inst read
    fall();
    inst_bus.req = 1'b1; inst_bus.addr = 32'h1c000000; mem_bus.addr_ok = 1'b1;
    settle();
    chk_eq("t1_mem_req", mem_bus.req, 1'b1);
    chk_eq("t1_mem_addr", mem_bus.addr, 32'h1c000000);
    chk_eq("t1_inst_addr_ok", inst_bus.addr_ok, 1'b1);
    chk_eq("t1_data_addr_ok", data_bus.addr_ok, 1'b0);
    fall(); inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b0; settle();
    chk_eq("t1_wait_mem_req", mem_bus.req, 1'b0);
    chk_eq("t1_wait_inst_dok", inst_bus.data_ok, 1'b0);
    fall(); mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h02800c0c; settle();
    chk_eq("t1_inst_dok", inst_bus.data_ok, 1'b1);
    chk_eq("t1_inst_rdata", inst_bus.rdata, 32'h02800c0c);
    chk_eq("t1_data_dok", data_bus.data_ok, 1'b0);
    fall(); mem_bus.data_ok = 1'b0; settle();
    chk_eq("t1_after_inst_dok", inst_bus.data_ok, 1'b0);

    // Simultaneous: data write first, inst granted the cycle after data_ok
    inst_bus.req = 1'b1; inst_bus.addr = 32'h1c000004;
    data_bus.req = 1'b1; data_bus.wr = 1'b1; data_bus.addr = 32'h00001000;
    data_bus.wstrb = 4'hF; data_bus.wdata = 32'hDEADBEEF; mem_bus.addr_ok = 1'b1;
    settle();
    chk_eq("t2_mem_addr", mem_bus.addr, 32'h00001000);
    chk_eq("t2_mem_wr", mem_bus.wr, 1'b1);
    chk_eq("t2_mem_wstrb", mem_bus.wstrb, 4'hF);
    chk_eq("t2_mem_wdata", mem_bus.wdata, 32'hDEADBEEF);
    chk_eq("t2_data_addr_ok", data_bus.addr_ok, 1'b1);
    chk_eq("t2_inst_addr_ok", inst_bus.addr_ok, 1'b0);
    fall(); data_bus.req = 1'b0; data_bus.wr = 1'b0; settle();
    chk_eq("t2_wait_mem_req", mem_bus.req, 1'b0);
    chk_eq("t2_wait_inst_addr_ok", inst_bus.addr_ok, 1'b0);
    fall(); mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h0; settle();
    chk_eq("t2_data_dok", data_bus.data_ok, 1'b1);
    chk_eq("t2_inst_dok", inst_bus.data_ok, 1'b0);
    chk_eq("t2_dok_cycle_inst_addr_ok", inst_bus.addr_ok, 1'b0);
    fall(); mem_bus.data_ok = 1'b0; settle();
    chk_eq("t2_inst_mem_addr", mem_bus.addr, 32'h1c000004);
    chk_eq("t2_inst_grant", inst_bus.addr_ok, 1'b1);
    fall(); inst_bus.req = 1'b0; mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h11112222; settle();
    chk_eq("t2_inst_dok2", inst_bus.data_ok, 1'b1);
    chk_eq("t2_inst_rdata", inst_bus.rdata, 32'h11112222);
    fall(); quiet_inputs();

    // Grant lock: inst holds the bus while mem_addr_ok is low
    fall();
    inst_bus.req = 1'b1; inst_bus.addr = 32'h1c000008; settle();
    chk_eq("t3_c0_mem_addr", mem_bus.addr, 32'h1c000008);
    chk_eq("t3_c0_inst_addr_ok", inst_bus.addr_ok, 1'b0);
    for (int c = 1; c < 3; c++) begin
      fall();
      data_bus.req = 1'b1; data_bus.addr = 32'h00002000; settle();
      chk_eq($sformatf("t3_c%0d_mem_addr", c), mem_bus.addr, 32'h1c000008);
      chk_eq($sformatf("t3_c%0d_mem_req", c), mem_bus.req, 1'b1);
      chk_eq($sformatf("t3_c%0d_data_addr_ok", c), data_bus.addr_ok, 1'b0);
    end
    fall(); mem_bus.addr_ok = 1'b1; settle();
    chk_eq("t3_c3_mem_addr", mem_bus.addr, 32'h1c000008);
    chk_eq("t3_c3_inst_addr_ok", inst_bus.addr_ok, 1'b1);
    chk_eq("t3_c3_data_addr_ok", data_bus.addr_ok, 1'b0);
    fall(); inst_bus.req = 1'b0; mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h33334444; settle();
    chk_eq("t3_inst_dok", inst_bus.data_ok, 1'b1);
    fall(); mem_bus.data_ok = 1'b0; settle();
    chk_eq("t3_data_mem_addr", mem_bus.addr, 32'h00002000);
    chk_eq("t3_data_addr_ok", data_bus.addr_ok, 1'b1);
    fall(); data_bus.req = 1'b0; mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h55556666; settle();
    chk_eq("t3_data_dok", data_bus.data_ok, 1'b1);
    chk_eq("t3_data_rdata", data_bus.rdata, 32'h55556666);
    fall(); quiet_inputs();

    // Starvation: both requesting continuously, expected D,D,D,D,I,D
    fall();
    inst_bus.req = 1'b1; inst_bus.addr = 32'h1c000010;
    data_bus.req = 1'b1; data_bus.addr = 32'h00003000;
    mem_bus.addr_ok = 1'b1;
    for (int g = 0; g < 6; g++) begin
      logic exp_data;
      exp_data = (g != 4);
      settle();
      chk_eq($sformatf("t4_g%0d_data_addr_ok", g), data_bus.addr_ok, 32'(exp_data));
      chk_eq($sformatf("t4_g%0d_inst_addr_ok", g), inst_bus.addr_ok, 32'(!exp_data));
      chk_eq($sformatf("t4_g%0d_mem_addr", g), mem_bus.addr,
             exp_data ? 32'h00003000 : 32'h1c000010);
      fall(); mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'(g); settle();
      chk_eq($sformatf("t4_g%0d_data_dok", g), data_bus.data_ok, 32'(exp_data));
      chk_eq($sformatf("t4_g%0d_inst_dok", g), inst_bus.data_ok, 32'(!exp_data));
      fall(); mem_bus.data_ok = 1'b0;
    end
    quiet_inputs();
    chk_eq("t4_err_clean", err_sticky, 1'b0);

    // Spurious response in IDLE
    fall(); mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'hBAD0BAD0; settle();
    chk_eq("t5_inst_dok", inst_bus.data_ok, 1'b0);
    chk_eq("t5_data_dok", data_bus.data_ok, 1'b0);
    fall(); mem_bus.data_ok = 1'b0; settle();
    chk_eq("t5_err_set", err_sticky, 1'b1);
    repeat (3) fall();
    settle();
    chk_eq("t5_err_holds", err_sticky, 1'b1);

    // Reset in WAIT_DATA, late response afterwards
    fall(); data_bus.req = 1'b1; data_bus.addr = 32'h00004000; mem_bus.addr_ok = 1'b1; settle();
    chk_eq("t6_data_addr_ok", data_bus.addr_ok, 1'b1);
    fall(); data_bus.req = 1'b0; mem_bus.addr_ok = 1'b0; reset = 1'b1;
    fall(); reset = 1'b0; settle();
    chk_eq("t6_err_cleared", err_sticky, 1'b0);
    fall(); mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h77778888; settle();
    chk_eq("t6_late_data_dok", data_bus.data_ok, 1'b0);
    chk_eq("t6_late_inst_dok", inst_bus.data_ok, 1'b0);
    fall(); mem_bus.data_ok = 1'b0; settle();
    chk_eq("t6_err_set", err_sticky, 1'b1);
    inst_bus.req = 1'b1; inst_bus.addr = 32'h1c00000c; mem_bus.addr_ok = 1'b1; settle();
    chk_eq("t6_inst_addr_ok", inst_bus.addr_ok, 1'b1);
    chk_eq("t6_inst_mem_addr", mem_bus.addr, 32'h1c00000c);
    fall(); inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b0;
    mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h12345678; settle();
    chk_eq("t6_inst_dok", inst_bus.data_ok, 1'b1);
    chk_eq("t6_inst_rdata", inst_bus.rdata, 32'h12345678);
    fall(); quiet_inputs(); settle();
    chk_eq("t6_err_still_set", err_sticky, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
